gselect_spec_predictor: RTL and testbench
=========================================

// Module: gselect_spec_predictor
// PURPOSE
//  Parametrised gselect predictor with speculative global history and in-order resolution.
//  Each prediction uses a PHT counter indexed by {PC low bits, GHR}. The GHR is updated
//  speculatively with each prediction. Each in-flight branch is held in a FIFO with its
//  index and a GHR snapshot. When the branch resolves, its counter is trained; on a
//  mispredict the GHR is repaired. Sits between fetch (predict port) and execute (resolve port).
// PARAMETERS
//  PC_W       8  width of pred_pc
//  PC_BITS    4  low PC bits used in index (PC_BITS <= PC_W)
//  HIST_BITS  4  GHR length; PHT has 2**(PC_BITS+HIST_BITS) entries
//  CTR_W      2  saturating counter width (>=1)
//  DEPTH      4  max unresolved branches (power of 2)
// PORTS
//  clk           input   1        rising-edge clock
//  reset         input   1        synchronous, active-low reset
//  pred_valid    input   1        prediction request
//  pred_ready    output  1        request accepted when pred_valid && pred_ready
//  pred_pc       input   PC_W     branch PC
//  pred_out_vld  output  1        prediction result valid (1 cycle after accept)
//  pred_taken    output  1        predicted direction (counter MSB)
//  res_valid     input   1        oldest in-flight branch resolves this cycle
//  res_taken     input   1        actual outcome of oldest branch
//  res_mispred   output  1        pulse, 1 cycle after res_valid: stored prediction != res_taken
//  inflight      output  $clog2(DEPTH)+1  count of unresolved branches
//  stat_branches output  32       resolved-branch count (GSEL_STATS_EN)
//  stat_mispred  output  32       mispredict count (GSEL_STATS_EN)
// BEHAVIOUR
//  - Reset (clk edge with reset==0):
//    - every PHT counter = 2**(CTR_W-1)-1 (weakly not-taken); GHR=0; FIFO empty.
//    - pred_out_vld=0, pred_taken=0, res_mispred=0, inflight=0; stats=0.
//    - Reset mid-operation discards all in-flight entries.
//  - Index: idx = {pred_pc[PC_BITS-1:0], ghr}.
//  - Accept cycle: pred_taken <= PHT[idx][CTR_W-1]; pred_out_vld <= 1 (latency 1).
//    - GHR <= {ghr[HIST_BITS-2:0], predicted bit}.
//    - Push {idx, predicted bit, pre-update ghr} to FIFO.
//  - pred_ready = !full && !(res_valid && mispredict-of-head). The mispredict check is combinational on the FIFO head.
//  - res_valid with FIFO empty: ignored; no counter, GHR or stat change; res_mispred=0.
//  - Resolve (FIFO head popped):
//    - PHT[head.idx] +1 if res_taken else -1, saturating at 0 and 2**CTR_W-1.
//    - If head.pred != res_taken: GHR <= {head.ghr[HIST_BITS-2:0], res_taken}; res_mispred <= 1 next cycle.
//    - Younger entries are NOT flushed by this block. The consumer is responsible for squashing them and must resolve them in order.
//  - Simultaneous accept and correct resolve: push and pop in same cycle; inflight unchanged.
//  - Full (inflight==DEPTH): pred_ready=0. A resolve in the same cycle frees a slot only the next cycle.
//  - PHT read/write collision, same cycle and same idx: read returns the pre-update value.
//  - FIFO pointers wrap modulo DEPTH.
// CONFIGURATION
//  GSEL_STATS_EN defined:
//    - stat_branches +1 per valid resolve; stat_mispred +1 per mispredict.
//    - Both wrap at 2**32.
//  GSEL_STATS_EN undefined:
//    - Ports remain present and are tied to 0; no counter flops are built.
// TESTING
//  1 Reset, then 3 predicts of pc=0x05, ghr=0 -> pred_taken=0,0,0; inflight=3; GHR=0.
//  2 Resolve 3 x taken at pc=0x05 (ghr 0) -> res_mispred=1 each; PHT[{5,0}] goes 1->2->3; stat_mispred=3 (STATS_EN).
//  3 Fill DEPTH=4 with no resolves -> pred_ready=0 on 5th request. Resolve one -> pred_ready=1 the next cycle.
//  4 Predict taken with ghr=4'b0011 -> GHR=0111. Resolve not-taken -> GHR=0110 and res_mispred=1.
//  5 Same-cycle predict and correct resolve at inflight=2 -> inflight stays 2; a counter at 3 with taken stays 3 (saturation).
//  6 Assert reset with inflight=3 -> next cycle inflight=0, pred_out_vld=0, and a fresh predict returns 0.

Source files
------------

// File: rtl/gselect_spec_predictor.sv
// gselect branch predictor: PHT indexed by {pc low bits, speculative GHR}, in-order resolve FIFO.
// Define GSEL_STATS_EN to build the resolved-branch and mispredict counters.
module gselect_spec_predictor #(
  parameter int PC_W      = 8,
  parameter int PC_BITS   = 4,
  parameter int HIST_BITS = 4,
  parameter int CTR_W     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [PC_W-1:0]        pred_pc,
  output logic                   pred_out_vld,
  output logic                   pred_taken,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_mispred,
  output logic [$clog2(DEPTH):0] inflight,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispred
);

  localparam int IDX_W = PC_BITS + HIST_BITS;
  localparam int PHT_N = 1 << IDX_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  function automatic logic [CTR_W-1:0] sat_ctr(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    else    return (c == '0)      ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [HIST_BITS-1:0] shift_hist(input logic [HIST_BITS-1:0] h,
                                                      input logic b);
    return HIST_BITS'({h, b});
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CTR_W-1:0]     pht      [PHT_N];
  logic [HIST_BITS-1:0] ghr;
  logic [IDX_W-1:0]     fifo_idx [DEPTH];
  logic                 fifo_pred[DEPTH];
  logic [HIST_BITS-1:0] fifo_ghr [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [IDX_W-1:0]     idx_p0;
  logic                 pred_bit_p0;
  logic                 fifo_empty, fifo_full;
  logic                 res_fire, mis_fire, pred_fire;
  logic                 vld_p1, pred_taken_p1, mispred_p1;
  logic                 unused_pc;

  // ---- p0: index, PHT lookup, head compare, handshake
  assign idx_p0      = {pred_pc[PC_BITS-1:0], ghr};
  assign pred_bit_p0 = pht[idx_p0][CTR_W-1];
  assign unused_pc   = ^pred_pc;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(DEPTH));
  assign res_fire    = res_valid && !fifo_empty;
  // A mispredicting resolve owns the GHR this cycle, so no new prediction may use it.
  assign mis_fire    = res_fire && (fifo_pred[rd_ptr] != res_taken);
  assign pred_ready  = !fifo_full && !mis_fire;
  assign pred_fire   = pred_valid && pred_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
    end else if (res_fire) begin
      pht[fifo_idx[rd_ptr]] <= sat_ctr(pht[fifo_idx[rd_ptr]], res_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (pred_fire) begin
      fifo_idx[wr_ptr]  <= idx_p0;
      fifo_pred[wr_ptr] <= pred_bit_p0;
      fifo_ghr[wr_ptr]  <= ghr;
    end
  end

  // ---- p1: registered prediction / mispredict outputs and speculative state
  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      vld_p1        <= 1'b0;
      pred_taken_p1 <= 1'b0;
      mispred_p1    <= 1'b0;
    end else begin
      vld_p1     <= pred_fire;
      mispred_p1 <= mis_fire;
      if (pred_fire) begin
        pred_taken_p1 <= pred_bit_p0;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (res_fire) rd_ptr <= ptr_inc(rd_ptr);
      if (mis_fire)       ghr <= shift_hist(fifo_ghr[rd_ptr], res_taken);
      else if (pred_fire) ghr <= shift_hist(ghr, pred_bit_p0);
      case ({pred_fire, res_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pred_out_vld = vld_p1;
  assign pred_taken   = pred_taken_p1;
  assign res_mispred  = mispred_p1;
  assign inflight     = count;

`ifdef GSEL_STATS_EN
  logic [31:0] stat_br_p1, stat_mis_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_br_p1  <= '0;
      stat_mis_p1 <= '0;
    end else begin
      if (res_fire) stat_br_p1  <= stat_br_p1 + 32'd1;
      if (mis_fire) stat_mis_p1 <= stat_mis_p1 + 32'd1;
    end
  end

  assign stat_branches = stat_br_p1;
  assign stat_mispred  = stat_mis_p1;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_gselect_spec_predictor.sv
// Scoreboard bench for gselect_spec_predictor: driver runs a queue-based reference model,
// a negedge monitor pops expected outputs and compares.
module tb_gselect_spec_predictor;

  localparam int PC_W      = 8;
  localparam int PC_BITS   = 4;
  localparam int HIST_BITS = 4;
  localparam int CTR_W     = 2;
  localparam int DEPTH     = 4;
  localparam int PHT_N     = 1 << (PC_BITS + HIST_BITS);
  localparam int CTR_TOP   = (1 << CTR_W) - 1;
  localparam int CTR_HALF  = 1 << (CTR_W - 1);

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   pred_valid = 1'b0;
  logic                   pred_ready;
  logic [PC_W-1:0]        pred_pc = '0;
  logic                   pred_out_vld;
  logic                   pred_taken;
  logic                   res_valid = 1'b0;
  logic                   res_taken = 1'b0;
  logic                   res_mispred;
  logic [$clog2(DEPTH):0] inflight;
  logic [31:0]            stat_branches;
  logic [31:0]            stat_mispred;

  gselect_spec_predictor #(
    .PC_W(PC_W), .PC_BITS(PC_BITS), .HIST_BITS(HIST_BITS), .CTR_W(CTR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_out_vld(pred_out_vld), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispred(res_mispred),
    .inflight(inflight), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; bit taken; } pred_e_t;
  typedef struct { int due; int inflight; bit taken; int unsigned sb; int unsigned sm; } stat_e_t;
  typedef struct { int idx; bit pred; int ghr; } br_e_t;

  pred_e_t pq[$];
  int      mq[$];
  stat_e_t sq[$];

  int          pht[PHT_N];
  int          m_ghr;
  br_e_t       m_fifo[$];
  int unsigned m_sb, m_sm;
  bit          m_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) pht[i] = CTR_HALF - 1;
    m_ghr = 0;
    m_fifo.delete();
    m_sb = 0;
    m_sm = 0;
    m_last = 0;
  endtask

  // One clock of stimulus; the model predicts what the next edge must produce.
  task automatic step(input bit rst_n, input bit pv, input logic [PC_W-1:0] pc,
                      input bit rv, input bit rt);
    bit    ready, rfire, mis, acc, p;
    int    idx;
    br_e_t h;
    @(negedge clk);
    reset = rst_n; pred_valid = pv; pred_pc = pc; res_valid = rv; res_taken = rt;
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      rfire = rv && (m_fifo.size() > 0);
      mis   = rfire && (m_fifo[0].pred != rt);
      ready = (m_fifo.size() < DEPTH) && !mis;
      check("pred_ready", pred_ready, ready);
      acc = pv && ready;
      p   = 0;
      idx = 0;
      if (acc) begin
        idx = (int'(pc) % (1 << PC_BITS)) * (1 << HIST_BITS) + m_ghr;
        p   = (pht[idx] >= CTR_HALF);
        pq.push_back('{cyc + 1, p});
        m_last = p;
      end
      if (rfire) begin
        h = m_fifo.pop_front();
        if (rt) pht[h.idx] = (pht[h.idx] == CTR_TOP) ? CTR_TOP : pht[h.idx] + 1;
        else    pht[h.idx] = (pht[h.idx] == 0) ? 0 : pht[h.idx] - 1;
        m_sb++;
        if (mis) begin
          m_sm++;
          mq.push_back(cyc + 1);
        end
      end
      if (acc) m_fifo.push_back('{idx, p, m_ghr});
      if (mis)      m_ghr = (h.ghr * 2 + int'(rt)) % (1 << HIST_BITS);
      else if (acc) m_ghr = (m_ghr * 2 + int'(p)) % (1 << HIST_BITS);
    end
    sq.push_back('{cyc + 1, m_fifo.size(), m_last, m_sb, m_sm});
  endtask

  // Monitor: compares everything due at this negedge.
  always @(negedge clk) begin
    stat_e_t s;
    pred_e_t e;
    bit      exp_vld, exp_mis;
    if (sq.size() > 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      check("inflight", inflight, s.inflight);
      check("pred_taken_hold", pred_taken, s.taken);
`ifdef GSEL_STATS_EN
      check("stat_branches", stat_branches, s.sb);
      check("stat_mispred", stat_mispred, s.sm);
`else
      check("stat_branches_tied", stat_branches, 0);
      check("stat_mispred_tied", stat_mispred, 0);
`endif
      exp_vld = (pq.size() > 0 && pq[0].due == cyc);
      check("pred_out_vld", pred_out_vld, exp_vld);
      if (exp_vld) begin
        e = pq.pop_front();
        check("pred_dir", pred_taken, e.taken);
      end
      exp_mis = (mq.size() > 0 && mq[0] == cyc);
      check("res_mispred", res_mispred, exp_mis);
      if (exp_mis) void'(mq.pop_front());
    end
  end

  initial begin
    bit          rs, pv, rv, rt;
    logic [7:0]  pc;

    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // Three not-taken predictions at pc 0x05 from a cold table.
    for (int i = 0; i < 3; i++) step(1, 1, 8'h05, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    check("t1_inflight", inflight, 3);

    // Resolve all three taken: each is a mispredict.
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 0, 0);
    check("t2_inflight", inflight, 0);
`ifdef GSEL_STATS_EN
    check("t2_stat_mispred", stat_mispred, 3);
`endif

    // Fill the FIFO; fifth request must stall, a correct resolve frees it a cycle later.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 8'h21, 0, 0);
    step(1, 1, 8'h21, 0, 0);
    check("t3_full_ready", pred_ready, 0);
    step(1, 1, 8'h21, 1, m_fifo[0].pred);
    step(1, 1, 8'h21, 0, 0);
    while (m_fifo.size() > 0) step(1, 0, 8'h00, 1, $urandom_range(0, 1));
    step(1, 0, 8'h00, 0, 0);

    // Reset with branches in flight discards them.
    for (int i = 0; i < 3; i++) step(1, 1, 8'h15, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    check("t6_inflight", inflight, 0);
    check("t6_out_vld", pred_out_vld, 0);
    step(1, 1, 8'h05, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    check("t6_fresh_pred", pred_taken, 0);

    // Randomized traffic concentrated on aliasing PCs to provoke read/write collisions.
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 199) != 0);
      pv = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 2))
        0:       pc = 8'h05;
        1:       pc = 8'h15;
        default: pc = 8'($urandom);
      endcase
      rv = ($urandom_range(0, 99) < 45);
      rt = 1'($urandom_range(0, 1));
      step(rs, pv, pc, rv, rt);
    end

    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    @(negedge clk);
    #2;
    check("queues_drained", pq.size() + mq.size() + sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
